// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers
// over a four-phase tx_req/tx_ack handshake. Optional watchdog: UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_req,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_ack,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CND_W = IDX_W + 1;

    if (NUM_REQ < 2 || TIMEOUT < 1) begin : g_param_check
        $error("uart_tx_sched: NUM_REQ must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        REQ_HI,
        REQ_LO
    } state_t;

    state_t           state;
    logic             ack_meta;
    logic             ack_s;
    logic [IDX_W-1:0] last;
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [CND_W-1:0] cand;
    logic             hi_done;
    logic             lo_done;
    logic             tmo_hit;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the two synchronizer stages.
    always_ff @(posedge clk or posedge rst) begin : ack_sync
        if (rst) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= tx_ack;
            ack_s    <= ack_meta;
        end
    end

    // Scan from farthest to nearest after `last`, so the nearest valid requester
    // is written last and wins without needing an early exit.
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = {1'b0, last} + CND_W'(k);
            if (cand >= CND_W'(NUM_REQ)) begin
                cand = cand - CND_W'(NUM_REQ);
            end
            if (req_valid[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign hi_done = (state == REQ_HI) && ack_s;
    assign lo_done = (state == REQ_LO) && !ack_s;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_err_q;

    // Counter stays at zero in IDLE and clears on every state change, so it
    // always measures cycles spent in the current wait state.
    assign tmo_hit = (state != IDLE) && !hi_done && !lo_done &&
                     (tmo_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin : tmo
        if (rst) begin
            tmo_cnt   <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            if (state == IDLE || hi_done || lo_done || tmo_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            if (tmo_hit) begin
                tmo_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin : fsm
        if (rst) begin
            state     <= IDLE;
            tx_req    <= 1'b0;
            busy      <= 1'b0;
            req_ready <= '0;
            tx_data   <= '0;
            grant_id  <= '0;
            last      <= IDX_W'(NUM_REQ - 1);
        end else begin
            req_ready <= '0;
            unique case (state)
                IDLE: begin
                    if (win_found) begin
                        state     <= REQ_HI;
                        tx_req    <= 1'b1;
                        busy      <= 1'b1;
                        req_ready <= NUM_REQ'(1) << win_idx;
                        tx_data   <= req_data[win_idx*DATA_W +: DATA_W];
                        grant_id  <= win_idx;
                        last      <= win_idx;
                    end
                end
                REQ_HI: begin
                    if (hi_done || tmo_hit) begin
                        state  <= REQ_LO;
                        tx_req <= 1'b0;
                    end
                end
                REQ_LO: begin
                    if (lo_done || tmo_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_req <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed steps plus randomized traffic
// checked against a round-robin reference model and a transmitter-side scoreboard.
module tb_uart_tx_sched;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       tx_req;
    logic [DATA_W-1:0]          tx_data;
    logic                       tx_ack;
    logic [$clog2(NUM_REQ)-1:0] grant_id;
    logic                       busy;
    logic                       timeout_err;

    // 0: loopback, 1: slow transmitter model, 2: forced level
    int   ack_mode;
    logic ack_force;
    logic slow_ack;

    int n_checks = 0;
    int n_fail   = 0;
    int last_m;

    logic [DATA_W-1:0] src_q [NUM_REQ][$];
    logic [DATA_W-1:0] acc_q [$];
    logic [DATA_W-1:0] xmit_q [$];

    assign tx_ack = (ack_mode == 0) ? tx_req :
                    (ack_mode == 1) ? slow_ack : ack_force;

    uart_tx_sched #(
        .NUM_REQ(NUM_REQ),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_req     (tx_req),
        .tx_data    (tx_data),
        .tx_ack     (tx_ack),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Transmitter on a clock at 1/16 of clk with random phase, reacting on both
    // of its edges; offsets end in 3 ns so it never coincides with a clk edge.
    initial begin
        slow_ack = 1'b0;
        #($urandom_range(0, 15) * 10 + 3);
        forever begin
            #80;
            if (ack_mode == 1) begin
                if (tx_req && !slow_ack) xmit_q.push_back(tx_data);
                slow_ack = tx_req;
            end else begin
                slow_ack = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: first valid requester after `last`, wrapping.
    function automatic int rr_pick(input logic [NUM_REQ-1:0] mask, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c = (last + k) % NUM_REQ;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (2) step();
        rst = 1'b0;
        last_m = NUM_REQ - 1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic drive_src();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = (src_q[i].size() != 0);
            req_data[i*DATA_W +: DATA_W] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
        end
    endtask

    initial begin
        int hi, busy_low, e, n, exp_w, prev_edge, n_acc, n_bad;
        logic prev_req;
        logic [DATA_W-1:0] prev_data, popped;

        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        ack_mode = 0;
        ack_force = 1'b0;
        repeat (2) step();

        check("rst_tx_req", 32'(tx_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        last_m = NUM_REQ - 1;

        // Single request from requester 2 with loopback ack
        step();
        req_valid = 4'b0100;
        req_data[2*DATA_W +: DATA_W] = 8'h5A;
        step();
        check("t1_req_ready", 32'(req_ready), 32'b0100);
        check("t1_tx_data", 32'(tx_data), 32'h5A);
        check("t1_grant_id", 32'(grant_id), 32'd2);
        check("t1_tx_req", 32'(tx_req), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        req_valid = '0;
        last_m = 2;
        hi = 1;
        busy_low = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) check("t1_ready_pulse", 32'(req_ready), 32'd0);
            if (tx_req) hi++;
            if (!busy && busy_low == 0) busy_low = k;
        end
        check("t1_tx_req_cycles", 32'(hi), 32'd3);
        check("t1_busy_low_edge", 32'(busy_low), 32'd6);

        // All requesters valid continuously: rotation and 7-cycle spacing
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = 8'($urandom);
        req_valid = '1;
        prev_edge = -1;
        n_acc = 0;
        e = 0;
        while (n_acc < 5 && e < 100) begin
            step();
            e++;
            if (req_ready != '0) begin
                exp_w = rr_pick(req_valid, last_m);
                check("t2_grant_id", 32'(grant_id), 32'(exp_w));
                check("t2_req_ready", 32'(req_ready), 32'd1 << exp_w);
                check("t2_tx_data", 32'(tx_data), 32'(req_data[exp_w*DATA_W +: DATA_W]));
                if (prev_edge >= 0) check("t2_spacing", 32'(e - prev_edge), 32'd7);
                prev_edge = e;
                last_m = exp_w;
                n_acc++;
                req_data[exp_w*DATA_W +: DATA_W] = 8'($urandom);
            end
        end
        check("t2_accepts", 32'(n_acc), 32'd5);
        req_valid = '0;
        wait_idle("t2_idle", 20);

        // Slow transmitter, 100 random bytes from random owners
        for (int i = 0; i < 100; i++) begin
            int o = $urandom_range(0, NUM_REQ - 1);
            src_q[o].push_back(8'($urandom));
        end
        acc_q.delete();
        xmit_q.delete();
        drive_src();
        ack_mode = 1;
        prev_req = 1'b0;
        prev_data = '0;
        e = 0;
        while ((acc_q.size() < 100 || busy) && e < 20000) begin
            step();
            e++;
            if (tx_req && prev_req) check("t3_data_stable", 32'(tx_data), 32'(prev_data));
            prev_req = tx_req;
            prev_data = tx_data;
            if (req_ready != '0) begin
                exp_w = rr_pick(req_valid, last_m);
                check("t3_grant_id", 32'(grant_id), 32'(exp_w));
                check("t3_req_ready", 32'(req_ready), 32'd1 << exp_w);
                if (exp_w >= 0) begin
                    check("t3_tx_data", 32'(tx_data), 32'(src_q[exp_w][0]));
                    popped = src_q[exp_w].pop_front();
                    acc_q.push_back(popped);
                    last_m = exp_w;
                end
                drive_src();
            end
        end
        check("t3_accepted", 32'(acc_q.size()), 32'd100);
        check("t3_transmitted", 32'(xmit_q.size()), 32'd100);
        n_bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (i >= acc_q.size() || i >= xmit_q.size() || acc_q[i] !== xmit_q[i]) n_bad++;
        end
        check("t3_sequence_errors", 32'(n_bad), 32'd0);
        req_valid = '0;
        repeat (2) step();
        ack_mode = 0;

        // Reset in REQ_HI while req_ready is still high
        ack_mode = 2;
        ack_force = 1'b0;
        req_valid = 4'b0010;
        req_data[1*DATA_W +: DATA_W] = 8'hC3;
        step();
        check("t4_accept", 32'(req_ready), 32'b0010);
        req_valid = '0;
        #2 rst = 1'b1;
        #1;
        check("t4_rst_tx_req", 32'(tx_req), 32'd0);
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_req_ready", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;
        last_m = NUM_REQ - 1;
        ack_mode = 0;
        req_valid = '1;
        step();
        exp_w = rr_pick(req_valid, last_m);
        check("t4_next_grant", 32'(grant_id), 32'(exp_w));
        check("t4_next_ready", 32'(req_ready), 32'd1 << exp_w);
        last_m = exp_w;
        req_valid = '0;
        wait_idle("t4_idle", 20);

`ifdef UART_TX_SCHED_TIMEOUT_EN
        // Ack never arrives: tx_req drops after TIMEOUT cycles, error is sticky
        ack_mode = 2;
        ack_force = 1'b0;
        req_valid = 4'b0001;
        req_data[DATA_W-1:0] = 8'h11;
        step();
        check("t5_accept", 32'(req_ready), 32'b0001);
        req_valid = '0;
        last_m = 0;
        hi = 0;
        n = 0;
        while (tx_req && n < 60) begin
            hi++;
            step();
            n++;
        end
        check("t5_tx_req_cycles", 32'(hi), 32'(TIMEOUT));
        check("t5_err_set", 32'(timeout_err), 32'd1);
        wait_idle("t5_idle", 10);
        repeat (5) step();
        check("t5_err_sticky", 32'(timeout_err), 32'd1);

        // Ack stuck high: REQ_LO times out, next request is still accepted
        ack_force = 1'b1;
        repeat (4) step();
        req_valid = 4'b0100;
        req_data[2*DATA_W +: DATA_W] = 8'h77;
        prev_edge = -1;
        n_acc = 0;
        e = 0;
        while (n_acc < 2 && e < 100) begin
            step();
            e++;
            if (req_ready != '0) begin
                check("t6_grant_id", 32'(grant_id), 32'd2);
                if (prev_edge >= 0) check("t6_spacing", 32'(e - prev_edge), 32'(TIMEOUT + 2));
                prev_edge = e;
                n_acc++;
            end
        end
        check("t6_accepts", 32'(n_acc), 32'd2);
        req_valid = '0;
        ack_force = 1'b0;
        wait_idle("t6_idle", 3 * TIMEOUT);
        check("t6_err_sticky", 32'(timeout_err), 32'd1);
`else
        // Ack never arrives: without the watchdog tx_req is held indefinitely
        ack_mode = 2;
        ack_force = 1'b0;
        req_valid = 4'b0001;
        req_data[DATA_W-1:0] = 8'h11;
        step();
        check("t5_accept", 32'(req_ready), 32'b0001);
        req_valid = '0;
        last_m = 0;
        hi = 0;
        for (int k = 0; k < 40; k++) begin
            if (tx_req) hi++;
            step();
        end
        check("t5_tx_req_held", 32'(hi), 32'd40);
        check("t5_busy_held", 32'(busy), 32'd1);
        check("t5_no_err", 32'(timeout_err), 32'd0);
        ack_force = 1'b1;
        n = 0;
        while (tx_req && n < 10) begin
            step();
            n++;
        end
        check("t5_late_ack_drop", 32'(tx_req), 32'd0);
        ack_force = 1'b0;
        wait_idle("t5_idle", 10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares the single UART transmitter among `NUM_REQ` byte producers in the `clk` domain. It accepts one byte at a time from the winning requester and delivers it to the transmitter over a four-phase `tx_req`/`tx_ack` handshake. `tx_ack` arrives asynchronously from the `uart_sampling_clk` domain and is synchronized inside the block. Because `tx_req` is level-held until acknowledged, no transfer can be missed because of the clock ratio.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, minimum 2.
- `DATA_W`, default 8: byte width.
- `TIMEOUT`, default 1024: maximum number of cycles spent in one wait state. Used only with `UART_TX_SCHED_TIMEOUT_EN`.

Ports (reset `rst` is asynchronous, active-high; clock is `clk`):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-high.
- `req_valid`  in  `NUM_REQ`  requester i has a byte pending.
- `req_data`  in  `NUM_REQ*DATA_W`  byte of requester i at `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  `NUM_REQ`  one-hot, one-cycle accept pulse.
- `tx_req`  out  1  request to the UART transmitter, level.
- `tx_data`  out  `DATA_W`  byte to transmit; stable while `tx_req`=1.
- `tx_ack`  in  1  transmitter acknowledge, asynchronous to `clk`.
- `grant_id`  out  `$clog2(NUM_REQ)`  index of the last accepted requester.
- `busy`  out  1  high whenever the state is not IDLE.
- `timeout_err`  out  1  sticky handshake-timeout flag.

## Operation
- `tx_ack` passes through a 2-flop synchronizer; its output is `ack_s`. Only `ack_s` is used internally.
- States:
  - **IDLE:** if any `req_valid` bit is set, select the winner and go to REQ_HI.
  - **REQ_HI:** `tx_req`=1. When `ack_s`=1, go to REQ_LO.
  - **REQ_LO:** `tx_req`=0. When `ack_s`=0, go to IDLE.
- Arbitration:
  - Round-robin, searching from `last+1` upward and wrapping at `NUM_REQ-1` to 0.
  - `last` resets to `NUM_REQ-1`, so requester 0 has first priority after reset.
  - `last` updates only on accept.
- Accept, on the edge leaving IDLE, all registered:
  - `tx_data` ← winner's byte.
  - `grant_id` ← winner index.
  - `req_ready` ← one-hot winner bit for exactly one cycle.
  - `tx_req` ← 1.
- Requesters must hold `valid` and `data` until they see `req_ready`, then drop `valid` or present the next byte. A `valid` still high when the scheduler next returns to IDLE counts as a new request.
- `req_valid` changes outside IDLE are ignored. Only one byte is in flight at a time.
- `tx_data` holds its last value after a transfer; it is not cleared.
- Asserting `rst` at any point, including mid-handshake, aborts the transfer. The transmitter must tolerate `tx_req` dropping.

Reset values: state IDLE; `tx_req`, `busy`, `timeout_err` = 0; `req_ready` = 0; `tx_data` = 0; `grant_id` = 0; `last` = `NUM_REQ-1`; synchronizer flops 0.

## Timing
- Accept edge E0: `tx_req` and `req_ready` are high in the cycle after E0.
- Synchronizer latency: 2 edges from a `tx_ack` change to `ack_s`, plus 1 edge for the state transition.
- With loopback (`tx_ack` = `tx_req`):
  - `tx_req` is high for 3 cycles.
  - The block returns to IDLE at E6.
  - The next accept occurs at E7, giving back-to-back transfers 7 cycles apart.
- `busy` is registered and mirrors state ≠ IDLE; it rises in the same cycle as `tx_req`.
- Simultaneous requests in IDLE: exactly one winner per accept, chosen by round-robin order; the losers wait.
- A request arriving during REQ_LO is served at the first IDLE edge; there is no IDLE bubble beyond one cycle.

## Configuration
`UART_TX_SCHED_TIMEOUT_EN`

With the macro defined:
- A cycle counter clears on entry to REQ_HI and to REQ_LO.
- If the counter reaches `TIMEOUT` in REQ_HI, force REQ_LO (`tx_req`=0).
- If it reaches `TIMEOUT` in REQ_LO, force IDLE.
- Either event sets `timeout_err`, which stays set until `rst`.

Without the macro:
- The block waits indefinitely in REQ_HI and REQ_LO.
- No counter is built.
- `timeout_err` is tied to 0.

## Test plan
- **Reset and single request:** after reset, req 2 valid with 0x5A and loopback ack → `req_ready`=0b0100 for 1 cycle, `tx_data`=0x5A, `grant_id`=2, `tx_req` high 3 cycles, `busy` low at E6.
- **All four requesters valid continuously, loopback:** grants in order 0,1,2,3,0 with accepts spaced exactly 7 cycles.
- **Slow ack:** `tx_ack` driven from a clock 1/16 of `clk`, with random phase → every byte acknowledged once, `tx_data` stable while `tx_req`=1, no lost or duplicated bytes across 100 transfers.
- **Reset mid-handshake:** `rst` pulsed while in REQ_HI → `tx_req`, `busy` and `req_ready` go to 0 immediately; the next grant goes to requester 0.
- **Timeout, `TIMEOUT`=16, macro defined:** `tx_ack` held at 0 → `tx_req` drops after 16 cycles, `timeout_err`=1 and stays set. The same stimulus without the macro keeps `tx_req`=1 indefinitely.
- **Ack stuck high, macro defined:** the block leaves REQ_LO after `TIMEOUT` cycles, returns to IDLE, and accepts the next request.
